crc32_engine: RTL and testbench
===============================

Name: crc32_engine

Overview:
Polymorphic CRC-32 datapath that sits directly downstream of the control register block. It consumes `crc_data_in`, `crc_start`, `crc_reset` and `crc_orient`, and returns `crc_data_out` and `crc_ready`. Each accepted 32-bit word is folded into a running reflected CRC-32 (IEEE) over several cycles. Orientation bits convert selected polynomial-tap XOR gates to XNOR, which gives the polymorphic variant.

Parameters:
- BITS_PER_CYCLE, 8: bits folded per clock. Legal values are 1, 2, 4, 8, 16, 32. Any other value is an elaboration error.

Ports:
- CLK  input  1  system clock, rising edge
- nRST  input  1  asynchronous active-low reset
- crc_data_in  input  WORD_SIZE(32)  word to fold; sampled on an accepted start
- crc_start  input  1  single-cycle request to fold `crc_data_in`
- crc_reset  input  1  synchronous re-init of the running CRC
- crc_orient  input  WORD_SIZE(32)  per-tap XNOR select; sampled on an accepted start
- crc_data_out  output  WORD_SIZE(32)  finalized CRC (~register) of all words since the last init
- crc_ready  output  1  high when idle and able to accept a start

Behaviour:
- Reset (nRST=0, async): state=IDLE, crc_q=CRC32_INIT (0xFFFFFFFF), result_q=0x00000000, crc_ready=1, step counter=0.
- States:
  - IDLE: crc_ready=1.
  - BUSY: crc_ready=0.
- IDLE to BUSY: on crc_start=1 with crc_reset=0, latch data_q=crc_data_in and orient_q=crc_orient, and clear the counter.
- BUSY, each cycle: apply BITS_PER_CYCLE bit steps, consuming data_q bits LSB first. Shift data_q right by BITS_PER_CYCLE and increment the counter.
- Bit step, for data bit d:
  - fb = crc[0] ^ d
  - crc' = (crc >> 1) ^ (fb ? CRC32_POLY : 0) ^ (orient_q & CRC32_POLY)
  - CRC32_POLY = 0xEDB88320 (reflected 0x04C11DB7).
  - Orient bits outside the tap positions have no effect.
  - With orient=0 the result is exactly standard CRC-32, with bytes fed little-endian.
- BUSY to IDLE: after 32/BITS_PER_CYCLE BUSY cycles.
  - On the final cycle's edge, result_q <= ~crc_next.
  - crc_ready rises that same edge.
- Latency: start accepted at edge N; crc_ready=0 from N; crc_ready=1 and crc_data_out valid from edge N + 32/BITS_PER_CYCLE (4 cycles at the default).
- `crc_data_out` = result_q. It is held stable throughout BUSY at the previous result.
- crc_start while BUSY: ignored. No queueing, no error flag.
- crc_reset (any state): next edge sets crc_q=CRC32_INIT, result_q=0x00000000, state=IDLE. An in-flight word is aborted and discarded.
- crc_reset and crc_start in the same cycle: reset wins and the start is dropped.
- Successive words chain: crc_q is not re-initialized between starts, only by crc_reset or nRST.
- nRST asserted mid-operation: immediate async return to the reset values above.
- Widths: all arithmetic is 32-bit. The counter is $clog2(32/BITS_PER_CYCLE)+1 bits and never wraps, because it is cleared on start.

Decomposition:
- Add to POLI_types_pkg:
  - CRC32_POLY and CRC32_INIT (32'hEDB88320, 32'hFFFFFFFF)
  - crc_state_t enum {CRC_IDLE, CRC_BUSY}
  - WORD_SIZE (already present)
- Sub-module crc32_bit_step: combinational single-bit update with inputs crc, d, orient and output crc'. Instantiate BITS_PER_CYCLE copies in a chained generate.

Test Plan:
- nRST low then high, no stimulus: crc_ready=1, crc_data_out=0x00000000.
- crc_reset, then start with data=0x00000000, orient=0: crc_ready low for 4 cycles, then crc_data_out=0x2144DF1C.
- crc_reset, then start with data=0xFFFFFFFF, orient=0: crc_data_out=0xFFFFFFFF.
- Orient masking:
  - crc_reset, then data=0x00000000, orient=0x00000001 (non-tap bit): crc_data_out=0x2144DF1C.
  - Repeat with orient=0x00000020 (tap bit): result differs from 0x2144DF1C and must match the bench reference model.
- Chaining and ignored starts:
  - Two back-to-back words 0x00000000: result equals the reference model CRC of 8 zero bytes (0x6522DF69).
  - A start pulsed while BUSY is ignored: busy time is unchanged and the final result equals the single-word result.
- Reset collisions:
  - crc_reset on BUSY cycle 2: next cycle crc_ready=1 and crc_data_out=0x00000000.
  - crc_reset and crc_start together: no BUSY.
  - nRST pulsed mid-word: reset values immediately.
  - Repeat the zero-word test with BITS_PER_CYCLE=1 (32-cycle latency) and BITS_PER_CYCLE=32 (1-cycle latency): same 0x2144DF1C.

Source files
------------

// File: rtl/POLI_types_pkg.sv
// ===========================================================================
// POLI_types_pkg : shared types and constants for the POLI datapath blocks
// Revision 1.0
// ===========================================================================
`default_nettype none

package POLI_types_pkg;

  localparam int          WORD_SIZE  = 32;
  localparam logic [31:0] CRC32_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

  typedef enum logic [0:0] {
    CRC_IDLE = 1'b0,
    CRC_BUSY = 1'b1
  } crc_state_t;

endpackage

`default_nettype wire

// File: rtl/crc32_bit_step.sv
// ===========================================================================
// crc32_bit_step : one reflected CRC-32 bit update with orient-selected XNOR taps
// Revision 1.0
// ===========================================================================
`default_nettype none

module crc32_bit_step
  import POLI_types_pkg::*;
(
  input  logic [WORD_SIZE-1:0] crc_i,
  input  logic                 d_i,
  input  logic [WORD_SIZE-1:0] orient_i,
  output logic [WORD_SIZE-1:0] crc_o
);

  logic w_fb;

  assign w_fb  = crc_i[0] ^ d_i;
  // An orient bit on a tap inverts that tap's XOR, i.e. turns it into XNOR.
  assign crc_o = (crc_i >> 1) ^ (w_fb ? CRC32_POLY : '0) ^ (orient_i & CRC32_POLY);

endmodule

`default_nettype wire

// File: rtl/crc32_engine.sv
// ===========================================================================
// crc32_engine : multi-cycle polymorphic CRC-32 folding one 32-bit word per start
// Revision 1.0
// ===========================================================================
`default_nettype none

module crc32_engine
  import POLI_types_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 8
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [WORD_SIZE-1:0] crc_data_in,
  input  logic                 crc_start,
  input  logic                 crc_reset,
  input  logic [WORD_SIZE-1:0] crc_orient,
  output logic [WORD_SIZE-1:0] crc_data_out,
  output logic                 crc_ready
);

  localparam int STEPS = WORD_SIZE / BITS_PER_CYCLE;
  localparam int CW    = $clog2(STEPS) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4 ||
        BITS_PER_CYCLE == 8 || BITS_PER_CYCLE == 16 || BITS_PER_CYCLE == 32))
  begin : g_bad_bits_per_cycle
    $error("crc32_engine: BITS_PER_CYCLE must be 1, 2, 4, 8, 16 or 32");
  end

  crc_state_t           state_q, state_d;
  logic [WORD_SIZE-1:0] crc_q, crc_d;
  logic [WORD_SIZE-1:0] result_q, result_d;
  logic [WORD_SIZE-1:0] data_q, data_d;
  logic [WORD_SIZE-1:0] orient_q, orient_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WORD_SIZE-1:0] w_crc_next;

  // Each stage owns its own nets so the chain is not one self-referencing vector.
  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    logic [WORD_SIZE-1:0] w_in;
    logic [WORD_SIZE-1:0] w_out;
    if (i == 0) begin : g_first
      assign w_in = crc_q;
    end else begin : g_next
      assign w_in = g_step[i-1].w_out;
    end
    crc32_bit_step u_step (
      .crc_i    (w_in),
      .d_i      (data_q[i]),
      .orient_i (orient_q),
      .crc_o    (w_out)
    );
  end

  assign w_crc_next = g_step[BITS_PER_CYCLE-1].w_out;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= CRC_IDLE;
      crc_q    <= CRC32_INIT;
      result_q <= '0;
      data_q   <= '0;
      orient_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      crc_q    <= crc_d;
      result_q <= result_d;
      data_q   <= data_d;
      orient_q <= orient_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    crc_d    = crc_q;
    result_d = result_q;
    data_d   = data_q;
    orient_d = orient_q;
    cnt_d    = cnt_q;
    if (crc_reset) begin
      state_d  = CRC_IDLE;
      crc_d    = CRC32_INIT;
      result_d = '0;
    end else begin
      case (state_q)
        CRC_IDLE: begin
          if (crc_start) begin
            data_d   = crc_data_in;
            orient_d = crc_orient;
            cnt_d    = '0;
            state_d  = CRC_BUSY;
          end
        end
        CRC_BUSY: begin
          crc_d  = w_crc_next;
          data_d = data_q >> BITS_PER_CYCLE;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == LAST_STEP) begin
            result_d = ~w_crc_next;
            state_d  = CRC_IDLE;
          end
        end
        default: state_d = CRC_IDLE;
      endcase
    end
  end

  assign crc_data_out = result_q;
  assign crc_ready    = (state_q == CRC_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_crc32_engine.sv
// ===========================================================================
// tb_crc32_engine : randomized self-checking bench against a word-level CRC model
// Revision 1.0
// ===========================================================================
`default_nettype none

module tb_crc32_engine;

  localparam int BPC = 8;
  localparam int LAT = 32 / BPC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        crc_start = 1'b0, start1 = 1'b0, start32 = 1'b0;
  logic        crc_reset = 1'b0;
  logic [31:0] data_in = '0, orient = '0;
  logic [31:0] dout, dout1, dout32;
  logic        rdy, rdy1, rdy32;

  int vectors = 0;
  int errors  = 0;
  logic [31:0] m_crc = 32'hFFFFFFFF;
  logic [31:0] m_res = 32'h0;

  always #5 clk = ~clk;

  crc32_engine #(.BITS_PER_CYCLE(BPC)) dut (
    .CLK(clk), .nRST(rst_n), .crc_data_in(data_in), .crc_start(crc_start),
    .crc_reset(crc_reset), .crc_orient(orient), .crc_data_out(dout), .crc_ready(rdy));

  crc32_engine #(.BITS_PER_CYCLE(1)) dut1 (
    .CLK(clk), .nRST(rst_n), .crc_data_in(data_in), .crc_start(start1),
    .crc_reset(crc_reset), .crc_orient(orient), .crc_data_out(dout1), .crc_ready(rdy1));

  crc32_engine #(.BITS_PER_CYCLE(32)) dut32 (
    .CLK(clk), .nRST(rst_n), .crc_data_in(data_in), .crc_start(start32),
    .crc_reset(crc_reset), .crc_orient(orient), .crc_data_out(dout32), .crc_ready(rdy32));

  // Whole-word reference: 32 serial bit steps, data LSB first.
  function automatic logic [31:0] ref_fold(input logic [31:0] c, input logic [31:0] d,
                                           input logic [31:0] o);
    logic [31:0] mask;
    logic        fb;
    mask = o & 32'hEDB88320;
    for (int k = 0; k < 32; k++) begin
      fb = c[0] ^ d[k];
      c  = (c >> 1) ^ (fb ? 32'hEDB88320 : 32'h0) ^ mask;
    end
    return c;
  endfunction

  task automatic model_reset();
    m_crc = 32'hFFFFFFFF;
    m_res = 32'h0;
  endtask

  task automatic model_word(input logic [31:0] d, input logic [31:0] o);
    m_crc = ref_fold(m_crc, d, o);
    m_res = ~m_crc;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    crc_reset = 1'b1;
    @(negedge clk);
    crc_reset = 1'b0;
    model_reset();
    chk("sync_reset_out", dout, 32'h0);
  endtask

  // Fold one word; optionally poke a spurious start while busy at iteration poke.
  task automatic run_word(input string tag, input logic [31:0] d, input logic [31:0] o,
                          input int poke);
    int          n;
    logic [31:0] prev;
    @(negedge clk);
    data_in = d; orient = o; crc_start = 1'b1;
    prev = dout;
    @(negedge clk);
    crc_start = 1'b0;
    data_in = $urandom; orient = $urandom;
    chk({tag, "_busy"}, {31'b0, rdy}, 32'h0);
    n = 0;
    do begin
      chk({tag, "_hold"}, dout, prev);
      crc_start = (n == poke);
      @(negedge clk);
      n++;
    end while (!rdy && n < 100);
    crc_start = 1'b0;
    model_word(d, o);
    chk({tag, "_latency"}, 32'(n), 32'(LAT));
    chk({tag, "_result"}, dout, m_res);
  endtask

  initial begin
    int n, n1, n32;
    repeat (2) @(negedge clk);
    chk("por_ready", {31'b0, rdy}, 32'h1);
    chk("por_out", dout, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", {31'b0, rdy}, 32'h1);
    chk("idle_out", dout, 32'h0);

    pulse_reset();
    run_word("zero", 32'h0, 32'h0, -1);
    chk("zero_const", dout, 32'h2144DF1C);

    pulse_reset();
    run_word("ones", 32'hFFFFFFFF, 32'h0, -1);
    chk("ones_const", dout, 32'hFFFFFFFF);

    pulse_reset();
    run_word("orient_nontap", 32'h0, 32'h00000001, -1);
    chk("orient_nontap_const", dout, 32'h2144DF1C);

    pulse_reset();
    run_word("orient_tap", 32'h0, 32'h00000020, -1);
    chk("orient_tap_differs", {31'b0, dout == 32'h2144DF1C}, 32'h0);

    pulse_reset();
    run_word("chain0", 32'h0, 32'h0, -1);
    run_word("chain1", 32'h0, 32'h0, -1);
    chk("chain_const", dout, 32'h6522DF69);

    pulse_reset();
    run_word("busy_start", 32'h0, 32'h0, 1);
    chk("busy_start_const", dout, 32'h2144DF1C);
    repeat (3) @(negedge clk);
    chk("busy_start_no_rerun", {31'b0, rdy}, 32'h1);
    chk("busy_start_out_stable", dout, 32'h2144DF1C);

    // Abort on the second busy cycle
    @(negedge clk);
    data_in = $urandom; crc_start = 1'b1;
    @(negedge clk);
    crc_start = 1'b0;
    @(negedge clk);
    crc_reset = 1'b1;
    @(negedge clk);
    crc_reset = 1'b0;
    model_reset();
    chk("abort_ready", {31'b0, rdy}, 32'h1);
    chk("abort_out", dout, 32'h0);
    repeat (LAT + 1) @(negedge clk);
    chk("abort_discarded", dout, 32'h0);

    // Reset and start together: reset wins
    @(negedge clk);
    data_in = 32'hDEADBEEF; crc_start = 1'b1; crc_reset = 1'b1;
    @(negedge clk);
    crc_start = 1'b0; crc_reset = 1'b0;
    chk("collide_ready", {31'b0, rdy}, 32'h1);
    @(negedge clk);
    chk("collide_no_busy", {31'b0, rdy}, 32'h1);
    run_word("after_collide", 32'h0, 32'h0, -1);

    // Asynchronous reset mid-word
    @(negedge clk);
    data_in = $urandom; crc_start = 1'b1;
    @(negedge clk);
    crc_start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("nrst_ready", {31'b0, rdy}, 32'h1);
    chk("nrst_out", dout, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run_word("after_nrst", 32'h0, 32'h0, -1);

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 7) == 0) pulse_reset();
      run_word("rand", $urandom, ($urandom_range(0, 1) == 1) ? $urandom : 32'h0, -1);
    end

    // Same zero word through the 1-bit and 32-bit variants
    pulse_reset();
    @(negedge clk);
    data_in = 32'h0; orient = 32'h0;
    crc_start = 1'b1; start1 = 1'b1; start32 = 1'b1;
    @(negedge clk);
    crc_start = 1'b0; start1 = 1'b0; start32 = 1'b0;
    chk("w1_busy", {31'b0, rdy1}, 32'h0);
    chk("w32_busy", {31'b0, rdy32}, 32'h0);
    n = 0; n1 = -1; n32 = -1;
    while ((n1 < 0 || n32 < 0) && n < 100) begin
      @(negedge clk);
      n++;
      if (n1 < 0 && rdy1) n1 = n;
      if (n32 < 0 && rdy32) n32 = n;
    end
    chk("w1_latency", 32'(n1), 32'd32);
    chk("w32_latency", 32'(n32), 32'd1);
    chk("w1_result", dout1, 32'h2144DF1C);
    chk("w32_result", dout32, 32'h2144DF1C);
    model_word(32'h0, 32'h0);
    chk("w8_result", dout, m_res);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
